// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole driver of the register file write port (WE3/A3/WD3).
// The ALU result path has fixed priority and cannot be stalled. Results from the
// multiply/divide unit (MDU) are queued in a small FIFO and written back when the
// ALU leaves the write slot free.
// The hazard output flags decode source registers whose newest value has not yet
// reached the register file.
// Optional feature: define WB_STAT_EN to add the conflict_cnt output. It counts
// cycles where a queued MDU result lost the write slot to the ALU.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_we,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_wd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard,
  output logic            WE3,
  output logic [4:0]      A3,
  output logic [XLEN-1:0] WD3
`ifdef WB_STAT_EN
  ,
  output logic [31:0]     conflict_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [DEPTH-1:0] fifo_vld;
  logic [4:0]      fifo_rd [DEPTH];
  logic [XLEN-1:0] fifo_wd [DEPTH];

  logic fifo_empty;
  logic alu_win;
  logic push;
  logic pop;

  // Ready depends only on the registered occupancy, never on this cycle's pop.
  // A write to x0 finishes the handshake but is not stored.
  // The FIFO pops only when the ALU does not claim the slot.
  always_comb begin
    fifo_empty = (count == '0);
    mdu_ready  = !reset && (count != FULL_CNT);
    alu_win    = alu_we && (alu_rd != 5'd0);
    push       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    pop        = !alu_win && !fifo_empty;
  end

  // FIFO control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_vld <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A clear and a set never target the same slot: a push needs a free entry.
      if (pop)  fifo_vld[rd_ptr] <= 1'b0;
      if (push) fifo_vld[wr_ptr] <= 1'b1;
    end
  end

  // FIFO payload storage: entries are qualified by fifo_vld, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr] <= mdu_rd;
      fifo_wd[wr_ptr] <= mdu_wd;
    end
  end

  // ---- stage boundary: write-port register feeding the register file ----
  // Output register: the ALU wins, otherwise the FIFO head is written, otherwise idle.
  // When idle, A3 and WD3 keep their previous values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else if (alu_win) begin
      WE3 <= 1'b1;
      A3  <= alu_rd;
      WD3 <= alu_wd;
    end else if (pop) begin
      WE3 <= 1'b1;
      A3  <= fifo_rd[rd_ptr];
      WD3 <= fifo_wd[rd_ptr];
    end else begin
      WE3 <= 1'b0;
    end
  end

  logic hit1;
  logic hit2;

  // Hazard: a source register matches the write in progress or any queued MDU result.
  always_comb begin
    hit1 = WE3 && (A3 == rs1);
    hit2 = WE3 && (A3 == rs2);
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_rd[i] == rs1)) hit1 = 1'b1;
      if (fifo_vld[i] && (fifo_rd[i] == rs2)) hit2 = 1'b1;
    end
    hazard = ((rs1 != 5'd0) && hit1) || ((rs2 != 5'd0) && hit2);
  end

`ifdef WB_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count cycles where a queued MDU result lost the slot to the ALU; saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (alu_win && !fifo_empty) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts
// every register-file write, tagged with the cycle it must appear in.
// A negedge monitor pops and compares these predictions whenever WE3 is high.
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_we;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_wd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            hazard;
  logic            WE3;
  logic [4:0]      A3;
  logic [XLEN-1:0] WD3;
`ifdef WB_STAT_EN
  logic [31:0]     conflict_cnt;
`endif

  regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .WE3(WE3), .A3(A3), .WD3(WD3)
`ifdef WB_STAT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  ent_t        mq[$];
  wr_t         exp_q[$];
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [31:0] m_conf;
  logic        m_rdy;
  ent_t        m_e;
  int unsigned cyc = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic m_haz(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    if (m_we && (m_a3 == rs)) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: a write-back slot per cycle, ALU first, else oldest queued MDU result.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_we   = 1'b0;
      m_a3   = '0;
      m_wd   = '0;
      m_conf = '0;
    end else begin
      cyc++;
      m_rdy = (mq.size() < DEPTH);
      if (alu_we && (alu_rd != 5'd0)) begin
        if (mq.size() != 0 && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 32'd1;
        m_we = 1'b1;
        m_a3 = alu_rd;
        m_wd = alu_wd;
      end else if (mq.size() != 0) begin
        m_e  = mq.pop_front();
        m_we = 1'b1;
        m_a3 = m_e.rd;
        m_wd = m_e.wd;
      end else begin
        m_we = 1'b0;
      end
      if (mdu_valid && m_rdy && (mdu_rd != 5'd0)) mq.push_back('{rd: mdu_rd, wd: mdu_wd});
      if (m_we) exp_q.push_back('{cyc: 32'(cyc), rd: m_a3, wd: m_wd});
    end
  end

  wr_t got;

  // Monitor: sample between active edges; pop a predicted write whenever WE3 is seen.
  always @(negedge clk) begin
    chk("mdu_ready", 64'(mdu_ready), 64'(!reset && (mq.size() < DEPTH)));
    chk("hazard", 64'(hazard), 64'(m_haz(rs1) || m_haz(rs2)));
    chk("WE3", 64'(WE3), 64'(m_we));
    chk("A3", 64'(A3), 64'(m_a3));
    chk("WD3", 64'(WD3), 64'(m_wd));
`ifdef WB_STAT_EN
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_conf));
`endif
    if (WE3) begin
      if (exp_q.size() == 0) begin
        chk("write_expected", 64'(1), 64'(0));
      end else begin
        got = exp_q.pop_front();
        chk("write_cycle", 64'(cyc), 64'(got.cyc));
        chk("write_addr", 64'(A3), 64'(got.rd));
        chk("write_data", 64'(WD3), 64'(got.wd));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_we    = 1'b0;
    mdu_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_we = 1'b0; alu_rd = '0; alu_wd = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_wd = '0;
    rs1 = '0; rs2 = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single ALU write, then idle with A3 held.
    alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    step();
    idle();
    repeat (3) step();

    // Single MDU result with the port free; hazard on rs1 while in flight.
    rs1 = 5'd7;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wd = 32'h12345678;
    step();
    idle();
    repeat (4) step();
    rs1 = 5'd0;

    // Starvation: continuous ALU writes fill the FIFO; ready drops; drain in order.
    alu_we = 1'b1; alu_rd = 5'd1; alu_wd = 32'h11111111;
    rs2 = 5'd4;
    for (int r = 2; r <= 5; r++) begin
      mdu_valid = 1'b1; mdu_rd = 5'(r); mdu_wd = 32'hA000_0000 + 32'(r);
      step();
    end
    mdu_rd = 5'd6; mdu_wd = 32'hA000_0006;
    repeat (2) step();
    idle();
    repeat (6) step();
    rs2 = 5'd0;

    // MDU write to x0 is swallowed; ALU write to x0 leaves the slot to the FIFO.
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_wd = 32'hBAD0BAD0;
    step();
    idle();
    repeat (2) step();
    alu_we = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33333333;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_wd = 32'h99999999;
    step();
    mdu_valid = 1'b0; alu_rd = 5'd0; alu_wd = 32'h00000BAD;
    repeat (2) step();
    idle();
    step();

    // Reset while the FIFO holds three entries and a write is on the port.
    rs1 = 5'd10; rs2 = 5'd8;
    alu_we = 1'b1; alu_rd = 5'd8; alu_wd = 32'h88888888;
    for (int r = 10; r <= 12; r++) begin
      mdu_valid = 1'b1; mdu_rd = 5'(r); mdu_wd = 32'hC000_0000 + 32'(r);
      step();
    end
    mdu_valid = 1'b0;
    reset = 1'b1;
    idle();
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();

    // Randomized traffic with occasional ALU-quiet windows and rare resets.
    for (int n = 0; n < 3000; n++) begin
      if ((n % 200) < 150) alu_we = ($urandom_range(0, 99) < 55);
      else                 alu_we = ($urandom_range(0, 99) < 10);
      alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_wd    = $urandom;
      mdu_valid = ($urandom_range(0, 99) < 45);
      mdu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      mdu_wd    = $urandom;
      rs1       = 5'($urandom_range(0, 15));
      rs2       = 5'($urandom_range(0, 15));
      reset     = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    rs1 = '0; rs2 = '0;
    repeat (10) step();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side companion to the 32x32 register file: the only driver of its single write port (WE3, A3, WD3).
- Merges two result sources onto that port: the single-cycle ALU/load path, which has fixed priority and no backpressure, and a long-latency multiply/divide unit (MDU) with a valid/ready handshake.
- MDU results are held in a small FIFO until a write slot is free.
- A hazard output tells decode when a source register still has an unwritten result in flight.

Parameters:
- XLEN, 32, data width of results and WD3.
- DEPTH, 4, MDU FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- alu_we  in  1  ALU result valid this cycle.
- alu_rd  in  5  ALU destination register.
- alu_wd  in  XLEN  ALU result.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  arbiter accepts MDU result.
- mdu_rd  in  5  MDU destination register.
- mdu_wd  in  XLEN  MDU result.
- rs1  in  5  decode source register 1.
- rs2  in  5  decode source register 2.
- hazard  out  1  pending write to nonzero rs1 or rs2.
- WE3  out  1  register file write enable, registered.
- A3  out  5  register file write address, registered.
- WD3  out  XLEN  register file write data, registered.

Behaviour:
- Reset: clears FIFO (count 0, pointers 0), WE3=0, A3=0, WD3=0. mdu_ready=0 while reset is high. Results in flight are discarded.
- Push: when mdu_valid && mdu_ready, the entry is enqueued at the edge. If mdu_rd==0, the handshake completes but nothing is enqueued.
- mdu_ready = (count < DEPTH). It is a function of registered count only; a same-cycle pop never raises ready when full.
- Write slot selection, evaluated every cycle:
  - If alu_we && alu_rd!=0: ALU wins; WE3<=1, A3<=alu_rd, WD3<=alu_wd.
  - Else if FIFO not empty: pop head; WE3<=1, A3/WD3 <= head.
  - Else WE3<=0, and A3/WD3 hold their previous values.
- alu_we with alu_rd==0 counts as no ALU write; the FIFO may pop that cycle.
- Latency:
  - ALU: valid in cycle N -> WE3=1 in cycle N+1 -> register file updated at end of N+1.
  - MDU with the port free: accepted in cycle N -> popped in N+1 -> WE3=1 in N+2.
  - No bypass path from mdu inputs straight to the output register.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap-around: pointers are modulo DEPTH.
- Ordering: FIFO entries write in arrival order.
- Starvation: continuous ALU writes block pops, so the FIFO fills and mdu_ready falls. Decode must resolve this by stalling on hazard or MDU busy.
- hazard is combinational. It is 1 iff rsX!=0 and rsX matches either:
  - A3 of the output register while WE3==1, or
  - mdu_rd of any valid FIFO entry.
  rs==0 never raises hazard. The register file write happens at the end of the WE3 cycle, so the output-register match is required.

Optional Feature:
- Macro: WB_STAT_EN.
- When defined, adds output port conflict_cnt (32 bits):
  - Reset 0.
  - Increments by 1 each cycle the FIFO is non-empty and the ALU wins the slot.
  - Saturates at 32'hFFFFFFFF.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then alu_we=1, alu_rd=5, alu_wd=32'hDEADBEEF for one cycle -> next cycle WE3=1, A3=5, WD3=32'hDEADBEEF; the cycle after, WE3=0 and A3 remains 5.
- With ALU idle, MDU offers rd=7, wd=32'h12345678 -> mdu_ready=1; WE3=1, A3=7 exactly two cycles after acceptance; rs1=7 gives hazard=1 from the acceptance edge until WE3 falls.
- Hold alu_we=1 (rd=1) continuously; push MDU results rd=2,3,4,5 -> mdu_ready=0 after the 4th; release ALU -> writes to 2,3,4,5 in order on consecutive cycles; mdu_ready=1 again the cycle after the first pop.
- MDU rd=0 accepted -> no FIFO entry, WE3 stays 0. alu_we=1 with alu_rd=0 alongside a pending FIFO entry -> FIFO entry is written. rs1=0 -> hazard=0 throughout.
- Assert reset while the FIFO holds 3 entries and WE3=1 -> immediately WE3=0, A3=0, WD3=0, hazard=0; after release no stale writes appear and mdu_ready=1.
- WB_STAT_EN defined: FIFO holds 1 entry and ALU writes for 3 cycles -> conflict_cnt=3; force the counter near all-ones -> it holds at 32'hFFFFFFFF.
